// File: rtl/aes_round_sequencer_if.sv
// Handshake and datapath-control bundle between the AES round sequencer and its
// producer/consumer and datapath.
interface aes_round_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic       abort;
    logic       out_ready;
    logic       out_valid;
    logic       busy;
    logic       state_we;
    logic       key_we;
    logic       ctl_init;
    logic       mix_bypass;
    logic [3:0] round_idx;
    logic [7:0] rcon;

    modport master (
        output in_valid, abort, out_ready,
        input  in_ready, out_valid, busy, state_we, key_we, ctl_init,
               mix_bypass, round_idx, rcon
    );

    modport slave (
        input  in_valid, abort, out_ready,
        output in_ready, out_valid, busy, state_we, key_we, ctl_init,
               mix_bypass, round_idx, rcon
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Control FSM for an iterative AES-128 datapath: accepts a block, sequences NR rounds
// around the SubBytes/mixColumns pipeline latencies and holds the ciphertext valid.
//
//   state | meaning
//   IDLE  | waiting for a plaintext/key block, in_ready high
//   ROUND | round_idx in 1..NR, cnt waits out the round pipeline latency
//   DONE  | ciphertext valid in the state register, waiting for out_ready
module aes_round_sequencer #(
    parameter int NR      = 10,
    parameter int SB_LAT  = 1,
    parameter int MIX_LAT = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    aes_round_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [2:0] TC_MID  = 3'(SB_LAT + MIX_LAT - 1);
    localparam logic [2:0] TC_LAST = 3'(SB_LAT - 1);
    localparam logic [3:0] NR_L    = 4'(NR);

    state_t     state;
    logic [2:0] cnt;
    logic [3:0] round_idx;
    logic [7:0] rcon;
    logic       out_valid;
    logic       busy;
    logic       mix_bypass;

    logic       accept;
    logic       last_round;
    logic       tc;
    logic       round_write;

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1B;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign accept      = (state == IDLE) && bus.in_valid && !bus.abort;
    assign last_round  = (round_idx == NR_L);
    // The final round skips mixColumns, so its wait is the SubBytes depth alone.
    assign tc          = (state == ROUND) && (cnt == (last_round ? TC_LAST : TC_MID));
    assign round_write = tc && !bus.abort;

    assign bus.in_ready   = (state == IDLE);
    assign bus.ctl_init   = accept;
    assign bus.state_we   = accept || round_write;
    assign bus.key_we     = accept || round_write;
    assign bus.out_valid  = out_valid;
    assign bus.busy       = busy;
    assign bus.mix_bypass = mix_bypass;
    assign bus.round_idx  = round_idx;
    assign bus.rcon       = rcon;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            round_idx  <= 4'd0;
            rcon       <= 8'h00;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            mix_bypass <= 1'b0;
        end else if (bus.abort) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            round_idx  <= 4'd0;
            rcon       <= 8'h00;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            mix_bypass <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= ROUND;
                        cnt        <= 3'd0;
                        round_idx  <= 4'd1;
                        rcon       <= rcon_of(4'd1);
                        busy       <= 1'b1;
                        mix_bypass <= (NR_L == 4'd1);
                    end
                end
                ROUND: begin
                    if (tc) begin
                        cnt <= 3'd0;
                        if (!last_round) begin
                            round_idx  <= round_idx + 4'd1;
                            rcon       <= rcon_of(round_idx + 4'd1);
                            mix_bypass <= ((round_idx + 4'd1) == NR_L);
                        end else begin
                            state      <= DONE;
                            round_idx  <= 4'd0;
                            rcon       <= 8'h00;
                            mix_bypass <= 1'b0;
                            out_valid  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: three parameterisations, write-event
// scoreboard built from the round-latency model when a block is accepted.
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    aes_round_sequencer_if ifa ();
    aes_round_sequencer_if ifb ();
    aes_round_sequencer_if ifc ();

    aes_round_sequencer #(.NR(10), .SB_LAT(1), .MIX_LAT(2)) dut_def (.clk(clk), .rst_n(rst_n), .bus(ifa));
    aes_round_sequencer #(.NR(10), .SB_LAT(1), .MIX_LAT(0)) dut_m0  (.clk(clk), .rst_n(rst_n), .bus(ifb));
    aes_round_sequencer #(.NR(1),  .SB_LAT(1), .MIX_LAT(2)) dut_nr1 (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int   sel = 0;
    int   p_nr = 10, p_sb = 1, p_mix = 2;
    logic in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;

    logic       in_ready, out_valid, busy, state_we, key_we, ctl_init, mix_bypass;
    logic [3:0] round_idx;
    logic [7:0] rcon;

    assign ifa.in_valid  = in_valid  && (sel == 0);
    assign ifa.abort     = abort     && (sel == 0);
    assign ifa.out_ready = out_ready && (sel == 0);
    assign ifb.in_valid  = in_valid  && (sel == 1);
    assign ifb.abort     = abort     && (sel == 1);
    assign ifb.out_ready = out_ready && (sel == 1);
    assign ifc.in_valid  = in_valid  && (sel == 2);
    assign ifc.abort     = abort     && (sel == 2);
    assign ifc.out_ready = out_ready && (sel == 2);

    always_comb begin
        {in_ready, out_valid, busy, state_we, key_we, ctl_init, mix_bypass} = '0;
        round_idx = '0;
        rcon = '0;
        case (sel)
            1: begin
                {in_ready, out_valid, busy, state_we, key_we, ctl_init, mix_bypass} =
                    {ifb.in_ready, ifb.out_valid, ifb.busy, ifb.state_we, ifb.key_we, ifb.ctl_init, ifb.mix_bypass};
                round_idx = ifb.round_idx;
                rcon = ifb.rcon;
            end
            2: begin
                {in_ready, out_valid, busy, state_we, key_we, ctl_init, mix_bypass} =
                    {ifc.in_ready, ifc.out_valid, ifc.busy, ifc.state_we, ifc.key_we, ifc.ctl_init, ifc.mix_bypass};
                round_idx = ifc.round_idx;
                rcon = ifc.rcon;
            end
            default: begin
                {in_ready, out_valid, busy, state_we, key_we, ctl_init, mix_bypass} =
                    {ifa.in_ready, ifa.out_valid, ifa.busy, ifa.state_we, ifa.key_we, ifa.ctl_init, ifa.mix_bypass};
                round_idx = ifa.round_idx;
                rcon = ifa.rcon;
            end
        endcase
    end

    typedef struct {
        int         edge_n;
        logic [3:0] r;
        logic [7:0] rc;
    } wr_t;

    wr_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    logic [7:0] rcon_tbl [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    task automatic select_cfg(input int s, input int nr, input int sb, input int mix);
        sel = s;
        p_nr = nr;
        p_sb = sb;
        p_mix = mix;
        in_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    // Expected write edges relative to the accepting edge; returns total latency.
    task automatic build_expected(output int lat);
        int  t;
        wr_t w;
        t = 0;
        sb_q.delete();
        for (int r = 1; r <= p_nr; r++) begin
            t += (r < p_nr) ? (p_sb + p_mix) : p_sb;
            w.edge_n = t;
            w.r = 4'(r);
            w.rc = rcon_tbl[r];
            sb_q.push_back(w);
        end
        lat = t;
    endtask

    // Starts just after a rising edge with the selected DUT in IDLE.
    task automatic run_block(input int bp, input bit hold_valid, output int acc_edge);
        int  lat;
        wr_t w;
        build_expected(lat);
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || ctl_init !== 1'b1 || state_we !== 1'b1 || key_we !== 1'b1) begin
            errors++;
            $display("FAIL accept: in_ready=%b ctl_init=%b state_we=%b key_we=%b, required 1 1 1 1",
                     in_ready, ctl_init, state_we, key_we);
        end
        @(posedge clk); #1;
        acc_edge = edge_cnt;
        if (!hold_valid) in_valid = 1'b0;
        out_ready = (bp == 0);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 || ctl_init !== 1'b0) begin
                errors++;
                $display("FAIL round_status cycle %0d: busy=%b out_valid=%b in_ready=%b ctl_init=%b, required 1 0 0 0",
                         k, busy, out_valid, in_ready, ctl_init);
            end
            checks++;
            if (mix_bypass !== (k > lat - p_sb)) begin
                errors++;
                $display("FAIL mix_bypass cycle %0d: got %b, required %b", k, mix_bypass, (k > lat - p_sb));
            end
            if (state_we === 1'b1 || key_we === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write cycle %0d: state_we=%b key_we=%b, required no write", k, state_we, key_we);
                end else begin
                    w = sb_q.pop_front();
                    if (w.edge_n != k || round_idx !== w.r || rcon !== w.rc || state_we !== 1'b1 || key_we !== 1'b1) begin
                        errors++;
                        $display("FAIL round_write: edge %0d round %0d rcon %h we %b%b, required edge %0d round %0d rcon %h we 11",
                                 k, round_idx, rcon, state_we, key_we, w.edge_n, w.r, w.rc);
                    end
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: %0d writes outstanding, required 0", sb_q.size());
        end
        for (int j = 0; j <= bp; j++) begin
            if (j == bp) out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || state_we !== 1'b0 ||
                key_we !== 1'b0 || round_idx !== 4'd0 || rcon !== 8'h00 || mix_bypass !== 1'b0) begin
                errors++;
                $display("FAIL done_hold %0d: ov=%b busy=%b ir=%b swe=%b kwe=%b ridx=%0d rcon=%h byp=%b, required 1 1 0 0 0 0 00 0",
                         j, out_valid, busy, in_ready, state_we, key_we, round_idx, rcon, mix_bypass);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || state_we !== 1'b0 ||
            key_we !== 1'b0 || round_idx !== 4'd0 || rcon !== 8'h00 || mix_bypass !== 1'b0) begin
            errors++;
            $display("FAIL %s: ir=%b busy=%b ov=%b swe=%b kwe=%b ridx=%0d rcon=%h byp=%b, required idle 1 0 0 0 0 0 00 0",
                     name, in_ready, busy, out_valid, state_we, key_we, round_idx, rcon, mix_bypass);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        check_idle("reset_values");
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (round_idx !== 4'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_round: round_idx=%0d busy=%b, required 4 1", round_idx, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || state_we !== 1'b0 || key_we !== 1'b0 ||
            ctl_init !== 1'b0 || mix_bypass !== 1'b0 || round_idx !== 4'd0 || rcon !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: ir=%b busy=%b ov=%b swe=%b kwe=%b init=%b byp=%b ridx=%0d rcon=%h, required reset values",
                     in_ready, busy, out_valid, state_we, key_we, ctl_init, mix_bypass, round_idx, rcon);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) check_idle("post_reset_idle");
    endtask

    task automatic test_single_block();
        int e;
        run_block(0, 1'b0, e);
        check_idle("single_return_idle");
    endtask

    task automatic test_backpressure();
        int e;
        run_block(5, 1'b0, e);
        check_idle("backpressure_return_idle");
    endtask

    task automatic test_abort();
        int  e;
        bit  saw_ov;
        in_valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (state_we !== 1'b0 || key_we !== 1'b0 || ctl_init !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_accept: swe=%b kwe=%b init=%b, required 0 0 0", state_we, key_we, ctl_init);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        in_valid = 1'b0;
        check_idle("abort_idle_not_accepted");
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (round_idx !== 4'd5 || state_we !== 1'b0 || key_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_cycle: round_idx=%0d swe=%b kwe=%b, required 5 0 0", round_idx, state_we, key_we);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        saw_ov = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1 || busy !== 1'b0) saw_ov = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (saw_ov) begin
            errors++;
            $display("FAIL abort_no_output: out_valid or busy asserted after abort, required both low");
        end
        run_block(0, 1'b0, e);
        check_idle("abort_recovery_idle");
    endtask

    task automatic test_back_to_back();
        int e1, e2;
        run_block(0, 1'b1, e1);
        run_block(0, 1'b1, e2);
        in_valid = 1'b0;
        checks++;
        if (e2 - e1 != 30) begin
            errors++;
            $display("FAIL back_to_back_spacing: got %0d edges, required 30", e2 - e1);
        end
        check_idle("back_to_back_idle");
    endtask

    task automatic test_params();
        int e;
        select_cfg(1, 10, 1, 0);
        check_idle("mix0_idle");
        run_block(0, 1'b0, e);
        check_idle("mix0_return_idle");
        select_cfg(2, 1, 1, 2);
        check_idle("nr1_idle");
        run_block(2, 1'b0, e);
        check_idle("nr1_return_idle");
        select_cfg(0, 10, 1, 2);
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single_block();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
